// File: rtl/flash_playback_ctrl.sv
// Flash sample playback controller: fetches 32-bit words (two 16-bit samples) from
// flash and plays the upper byte of each sample on sample_tick, forward or backward.
module flash_playback_ctrl #(
  parameter logic [22:0] START_ADDR = 23'h000000,
  parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic        fF,
  input  logic        bF,
  input  logic        pause,
  input  logic        restart,
  output logic        flash_read,
  output logic [22:0] flash_address,
  input  logic        flash_waitrequest,
  input  logic        flash_readdatavalid,
  input  logic [31:0] flash_readdata,
  output logic [23:0] adr,
  output logic [7:0]  audio_out,
  output logic        sample_valid
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitData,
    StPlayFirst,
    StPlaySecond,
    StAdvance
  } state_e;

  state_e      state_q, state_d;
  logic [22:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic        fwd_q, fwd_d;
  logic [7:0]  audio_q, audio_d;
  logic        valid_q, valid_d;
  // Set when restart is seen while a bus transaction is in flight; the returned word
  // is then dropped instead of played.
  logic        discard_q, discard_d;
  logic        live_fwd;
  logic        play_ok;

  // Forward wins when both flags are set, and is the default when neither is.
  assign live_fwd = fF | ~bF;
  assign play_ok  = sample_tick & ~pause;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= START_ADDR;
      word_q    <= 32'h0;
      fwd_q     <= 1'b1;
      audio_q   <= 8'h00;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      fwd_q     <= fwd_d;
      audio_q   <= audio_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    fwd_d     = fwd_q;
    audio_d   = audio_q;
    valid_d   = 1'b0;
    discard_d = discard_q;
    case (state_q)
      StIdle: begin
        if (restart) addr_d = START_ADDR;
        state_d = StReq;
      end
      StReq: begin
        // The request is never withdrawn; restart only marks the data for discard.
        if (restart) discard_d = 1'b1;
        if (!flash_waitrequest) state_d = StWaitData;
      end
      StWaitData: begin
        if (restart) discard_d = 1'b1;
        if (flash_readdatavalid) begin
          if (discard_q || restart) begin
            addr_d    = START_ADDR;
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            word_d  = flash_readdata;
            fwd_d   = live_fwd;
            state_d = StPlayFirst;
          end
        end
      end
      StPlayFirst: begin
        if (restart) begin
          addr_d  = START_ADDR;
          state_d = StReq;
        end else if (play_ok) begin
          audio_d = fwd_q ? word_q[15:8] : word_q[31:24];
          valid_d = 1'b1;
          state_d = StPlaySecond;
        end
      end
      StPlaySecond: begin
        if (restart) begin
          addr_d  = START_ADDR;
          state_d = StReq;
        end else if (play_ok) begin
          audio_d = fwd_q ? word_q[31:24] : word_q[15:8];
          valid_d = 1'b1;
          state_d = StAdvance;
        end
      end
      StAdvance: begin
        if (restart) begin
          addr_d = START_ADDR;
        end else if (live_fwd) begin
          addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + 23'd1;
        end else begin
          addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - 23'd1;
        end
        state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  assign flash_read    = (state_q == StReq);
  assign flash_address = addr_q;
  assign adr           = {1'b0, addr_q};
  assign audio_out     = audio_q;
  assign sample_valid  = valid_q;

endmodule
